multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the 16-bit DPFinal datapath. It decodes the 4-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back over several clock cycles. It drives the datapath's mux selects and write strobes, and supplies `ALUop` to the ALU control block, which combines it with `funct` to form `operation`. Memory accesses use a ready handshake, so the unit stalls for any number of wait states.

## Interface
- `HALT_OP`, default 4'b1111: opcode that stops sequencing.
- `clk`  in  1: rising-edge clock for all state.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  4: IR[15:12]; sampled in DECODE only.
- `zero`  in  1: ALU zero flag; sampled in BRANCH only.
- `mem_ready`  in  1: memory completes the current access in this cycle.
- `ALUop`  out  2: 00 add, 01 subtract, 11 R-type (use `funct`); 10 never driven.
- `alu_src_a`  out  1: 0 = PC, 1 = register A.
- `alu_src_b`  out  2: 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
- `i_or_d`  out  1: memory address; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each: strobes.
- `reg_dst`  out  1: destination register; 1 = rd, 0 = rt.
- `mem_to_reg`  out  1: write-back data; 1 = MDR, 0 = ALUOut.
- `pc_write`  out  1: PC load enable.
- `pc_source`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted`  out  1: high while in HALT.
- `illegal`  out  1: one-cycle pulse when an undefined opcode is decoded.

## Operation
Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 JMP, `HALT_OP` HALT. All others are illegal.

Every output not listed for a state is 0.

States and actions:
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALUop`=00.
  - `ir_write`=1, `pc_write`=1 and `pc_source`=00 only in the cycle `mem_ready`=1.
  - Transition to DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=10, `ALUop`=00 (precomputes the branch target into ALUOut).
  - Dispatch on opcode: R-type → EXEC_R; LW/SW → MEM_ADDR; BEQ → BRANCH; ADDI → EXEC_I; JMP → JUMP; HALT → HALT.
  - Illegal opcode → FETCH with `illegal`=1 for this cycle; the instruction behaves as a NOP.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=11 → WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `ALUop`=00 → WB_I.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALUop`=00 → MEM_RD for LW, MEM_WR for SW (opcode held in a register captured at DECODE).
- MEM_RD: `mem_read`=1, `i_or_d`=1. Stay until `mem_ready`=1, then → WB_MEM.
- WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Stay until `mem_ready`=1, then → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=01, `pc_source`=01.
  - `pc_write`=`zero`, evaluated combinationally in this cycle.
  - → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10 → FETCH.
- HALT: `halted`=1; stays in HALT until `reset`.

## Timing
- Reset:
  - Any clock edge with `reset`=1 forces state to FETCH and clears the latched opcode.
  - While `reset`=1, every output is 0, including `mem_read` and `halted`, regardless of state.
  - Reset overrides everything: a reset asserted mid-memory-access drops the access without completing it.
- Output timing:
  - All outputs are combinational from the current state.
  - The only exceptions are the FETCH strobes (qualified by `mem_ready`) and BRANCH `pc_write` (qualified by `zero`).
  - Outputs change only after a clock edge or a change in those inputs.
- Cycle counts with zero wait states (`mem_ready` already high):
  - R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, JMP 3, illegal 2.
  - Each wait state adds 1 cycle to FETCH, MEM_RD or MEM_WR.
- `mem_ready` is ignored in every state except FETCH, MEM_RD and MEM_WR.
- `mem_read` and `mem_write` are never high in the same cycle.
- `pc_write` and `reg_write` are never high in the same cycle.
- `opcode` changes outside DECODE have no effect.

## Test plan
- Reset and hold: `reset`=1 for 2 cycles, then `mem_ready`=0 for 3 cycles → all outputs 0 during reset; then FETCH with `mem_read`=1 and `ir_write`=0 for 3 cycles.
- R-type: `mem_ready`=1, opcode 0000 → cycle 1 `ir_write`=`pc_write`=1; cycle 3 `ALUop`=11; cycle 4 `reg_write`=1, `reg_dst`=1; cycle 5 back in FETCH.
- LW with 2 wait states in MEM_RD: opcode 0001 → `mem_read`=1 and `i_or_d`=1 for 3 cycles; WB_MEM `mem_to_reg`=1; total 7 cycles.
- BEQ taken and not taken: opcode 0011 with `zero`=1 → `pc_write`=1, `pc_source`=01, `ALUop`=01; repeat with `zero`=0 → `pc_write`=0; both take 3 cycles.
- Illegal and HALT: opcode 0110 → `illegal` pulses for 1 cycle in DECODE, then FETCH. Opcode 1111 → `halted`=1 for 10 cycles with no strobes; `reset`=1 → FETCH, `halted`=0.
- Reset mid-SW: assert `reset` while in MEM_WR with `mem_ready`=0 → `mem_write` drops to 0 in the same cycle; next state is FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundles the signals exchanged between the multicycle control unit and the
// DPFinal datapath / memory.
//   Status into the controller : opcode (IR[15:12]), zero (ALU flag),
//                                mem_ready (memory access completes)
//   Controls out of controller : ALUop, alu_src_a, alu_src_b, i_or_d,
//                                mem_read, mem_write, ir_write, reg_write,
//                                reg_dst, mem_to_reg, pc_write, pc_source,
//                                halted, illegal
// Modports:
//   slave  - the control unit (consumes status, drives controls)
//   master - the datapath / memory side (drives status, consumes controls)
// -----------------------------------------------------------------------------
interface multicycle_control_if;
   logic [3:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic [1:0] ALUop;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       pc_write;
   logic [1:0] pc_source;
   logic       halted;
   logic       illegal;

   modport slave (
      input  opcode, zero, mem_ready,
      output ALUop, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_source,
             halted, illegal
   );

   modport master (
      output opcode, zero, mem_ready,
      input  ALUop, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_source,
             halted, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multicycle sequencer for the 16-bit DPFinal datapath. Steps each
// instruction through fetch, decode, execute, memory and write-back, driving
// the datapath mux selects and write strobes. Memory accesses wait on
// mem_ready, so any number of wait states is tolerated.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; also forces every output to 0 while high
//   bus   - multicycle_control_if.slave (status in, controls out)
// Parameter:
//   HALT_OP - opcode that parks the unit in HALT until reset
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter logic [3:0] HALT_OP = 4'b1111
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.slave  bus
);

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b0001;
   localparam logic [3:0] OP_SW    = 4'b0010;
   localparam logic [3:0] OP_BEQ   = 4'b0011;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_JMP   = 4'b0101;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_opcode;   // opcode captured in DECODE, steers MEM_ADDR

   logic [1:0] w_alu_op;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic       w_i_or_d;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_pc_write;
   logic [1:0] w_pc_source;
   logic       w_halted;
   logic       w_illegal;

   // State register and opcode latch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_opcode <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_DECODE) begin
            r_opcode <= bus.opcode;
         end
      end
   end

   // Next state and outputs. Reset blanks every output combinationally so an
   // in-flight memory access is dropped in the very cycle reset is raised.
   always_comb begin
      w_state_next = r_state;
      w_alu_op     = 2'b00;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_i_or_d     = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_source  = 2'b00;
      w_halted     = 1'b0;
      w_illegal    = 1'b0;

      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               w_mem_read  = 1'b1;
               w_alu_src_b = 2'b01;
               // IR load and PC+1 only commit on the cycle memory delivers
               if (bus.mem_ready) begin
                  w_ir_write   = 1'b1;
                  w_pc_write   = 1'b1;
                  w_state_next = S_DECODE;
               end
            end

            S_DECODE: begin
               // ALU precomputes PC + imm as the branch target
               w_alu_src_b = 2'b10;
               if (bus.opcode == HALT_OP) begin
                  w_state_next = S_HALT;
               end else begin
                  case (bus.opcode)
                     OP_RTYPE: w_state_next = S_EXEC_R;
                     OP_LW,
                     OP_SW:    w_state_next = S_MEM_ADDR;
                     OP_BEQ:   w_state_next = S_BRANCH;
                     OP_ADDI:  w_state_next = S_EXEC_I;
                     OP_JMP:   w_state_next = S_JUMP;
                     default: begin
                        w_illegal    = 1'b1;
                        w_state_next = S_FETCH;
                     end
                  endcase
               end
            end

            S_EXEC_R: begin
               w_alu_src_a  = 1'b1;
               w_alu_op     = 2'b11;
               w_state_next = S_WB_R;
            end

            S_WB_R: begin
               w_reg_write  = 1'b1;
               w_reg_dst    = 1'b1;
               w_state_next = S_FETCH;
            end

            S_EXEC_I: begin
               w_alu_src_a  = 1'b1;
               w_alu_src_b  = 2'b10;
               w_state_next = S_WB_I;
            end

            S_WB_I: begin
               w_reg_write  = 1'b1;
               w_state_next = S_FETCH;
            end

            S_MEM_ADDR: begin
               w_alu_src_a  = 1'b1;
               w_alu_src_b  = 2'b10;
               w_state_next = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
               w_mem_read = 1'b1;
               w_i_or_d   = 1'b1;
               if (bus.mem_ready) begin
                  w_state_next = S_WB_MEM;
               end
            end

            S_WB_MEM: begin
               w_reg_write  = 1'b1;
               w_mem_to_reg = 1'b1;
               w_state_next = S_FETCH;
            end

            S_MEM_WR: begin
               w_mem_write = 1'b1;
               w_i_or_d    = 1'b1;
               if (bus.mem_ready) begin
                  w_state_next = S_FETCH;
               end
            end

            S_BRANCH: begin
               w_alu_src_a  = 1'b1;
               w_alu_op     = 2'b01;
               w_pc_source  = 2'b01;
               w_pc_write   = bus.zero;
               w_state_next = S_FETCH;
            end

            S_JUMP: begin
               w_pc_write   = 1'b1;
               w_pc_source  = 2'b10;
               w_state_next = S_FETCH;
            end

            S_HALT: begin
               w_halted = 1'b1;
            end

            default: begin
               w_state_next = S_FETCH;
            end
         endcase
      end
   end

   assign bus.ALUop      = w_alu_op;
   assign bus.alu_src_a  = w_alu_src_a;
   assign bus.alu_src_b  = w_alu_src_b;
   assign bus.i_or_d     = w_i_or_d;
   assign bus.mem_read   = w_mem_read;
   assign bus.mem_write  = w_mem_write;
   assign bus.ir_write   = w_ir_write;
   assign bus.reg_write  = w_reg_write;
   assign bus.reg_dst    = w_reg_dst;
   assign bus.mem_to_reg = w_mem_to_reg;
   assign bus.pc_write   = w_pc_write;
   assign bus.pc_source  = w_pc_source;
   assign bus.halted     = w_halted;
   assign bus.illegal    = w_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Drives instruction sequences into multicycle_control with random wait
// states, random don't-care inputs and random opcode noise outside DECODE.
// For every cycle driven, the expected control word (from a per-instruction
// reference of the control sequence) is queued; a monitor on the falling edge
// pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   typedef struct packed {
      logic [1:0] aluop;
      logic       src_a;
      logic [1:0] src_b;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       halted;
      logic       illegal;
   } outs_t;

   localparam logic [3:0] HALT = 4'b1111;

   logic clk;
   logic reset;

   multicycle_control_if bus();

   multicycle_control #(.HALT_OP(HALT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   outs_t exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         outs_t g;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         g.aluop      = bus.ALUop;
         g.src_a      = bus.alu_src_a;
         g.src_b      = bus.alu_src_b;
         g.i_or_d     = bus.i_or_d;
         g.mem_read   = bus.mem_read;
         g.mem_write  = bus.mem_write;
         g.ir_write   = bus.ir_write;
         g.reg_write  = bus.reg_write;
         g.reg_dst    = bus.reg_dst;
         g.mem_to_reg = bus.mem_to_reg;
         g.pc_write   = bus.pc_write;
         g.pc_source  = bus.pc_source;
         g.halted     = bus.halted;
         g.illegal    = bus.illegal;
         n_checks++;
         if (g === e) begin
            n_pass++;
         end else begin
            $display("FAIL %s @%0t: got %05h required %05h", nm, $time, g, e);
         end
      end
   end

   // ---------------- reference: control word per step ----------------
   function automatic outs_t o_fetch(input logic done);
      outs_t o = '0;
      o.mem_read = 1'b1;
      o.src_b    = 2'b01;
      o.ir_write = done;
      o.pc_write = done;
      return o;
   endfunction

   function automatic outs_t o_decode(input logic ill);
      outs_t o = '0;
      o.src_b   = 2'b10;
      o.illegal = ill;
      return o;
   endfunction

   function automatic outs_t o_alu(input logic [1:0] op, input logic [1:0] b);
      outs_t o = '0;
      o.src_a = 1'b1;
      o.src_b = b;
      o.aluop = op;
      return o;
   endfunction

   function automatic outs_t o_wb(input logic dst, input logic m2r);
      outs_t o = '0;
      o.reg_write  = 1'b1;
      o.reg_dst    = dst;
      o.mem_to_reg = m2r;
      return o;
   endfunction

   function automatic outs_t o_mem(input logic wr);
      outs_t o = '0;
      o.i_or_d    = 1'b1;
      o.mem_read  = !wr;
      o.mem_write = wr;
      return o;
   endfunction

   function automatic outs_t o_branch(input logic z);
      outs_t o = '0;
      o.src_a     = 1'b1;
      o.aluop     = 2'b01;
      o.pc_source = 2'b01;
      o.pc_write  = z;
      return o;
   endfunction

   function automatic outs_t o_jump();
      outs_t o = '0;
      o.pc_write  = 1'b1;
      o.pc_source = 2'b10;
      return o;
   endfunction

   function automatic outs_t o_halt();
      outs_t o = '0;
      o.halted = 1'b1;
      return o;
   endfunction

   function automatic logic [3:0] r4();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic r1();
      return 1'($urandom_range(0, 1));
   endfunction

   // ---------------- stimulus ----------------
   task automatic cyc(input logic rst, input logic [3:0] op, input logic z,
                      input logic mr, input outs_t e, input string nm);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = mr;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic do_fetch(input int waits);
      for (int i = 0; i < waits; i++) cyc(1'b0, r4(), r1(), 1'b0, o_fetch(1'b0), "fetch_wait");
      cyc(1'b0, r4(), r1(), 1'b1, o_fetch(1'b1), "fetch");
   endtask

   task automatic do_mem(input logic wr, input int waits);
      for (int i = 0; i < waits; i++) cyc(1'b0, r4(), r1(), 1'b0, o_mem(wr), "mem_wait");
      cyc(1'b0, r4(), r1(), 1'b1, o_mem(wr), "mem_done");
   endtask

   task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
      logic legal;
      legal = (op <= 4'd5) || (op == HALT);
      $display("instr op=%b zero=%0d fetch_waits=%0d mem_waits=%0d", op, z, fw, mw);
      do_fetch(fw);
      cyc(1'b0, op, r1(), r1(), o_decode(!legal), "decode");
      if (op == HALT) begin
         for (int i = 0; i < 10; i++) cyc(1'b0, r4(), r1(), r1(), o_halt(), "halt");
      end else begin
         case (op)
            4'd0: begin
               cyc(1'b0, r4(), r1(), r1(), o_alu(2'b11, 2'b00), "exec_r");
               cyc(1'b0, r4(), r1(), r1(), o_wb(1'b1, 1'b0), "wb_r");
            end
            4'd1: begin
               cyc(1'b0, r4(), r1(), r1(), o_alu(2'b00, 2'b10), "mem_addr_lw");
               do_mem(1'b0, mw);
               cyc(1'b0, r4(), r1(), r1(), o_wb(1'b0, 1'b1), "wb_mem");
            end
            4'd2: begin
               cyc(1'b0, r4(), r1(), r1(), o_alu(2'b00, 2'b10), "mem_addr_sw");
               do_mem(1'b1, mw);
            end
            4'd3: cyc(1'b0, r4(), z, r1(), o_branch(z), "branch");
            4'd4: begin
               cyc(1'b0, r4(), r1(), r1(), o_alu(2'b00, 2'b10), "exec_i");
               cyc(1'b0, r4(), r1(), r1(), o_wb(1'b0, 1'b0), "wb_i");
            end
            4'd5: cyc(1'b0, r4(), r1(), r1(), o_jump(), "jump");
            default: ;
         endcase
      end
   endtask

   initial begin
      logic [3:0] op;
      reset         = 1'b1;
      bus.opcode    = 4'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;

      // Reset and hold, then FETCH stalled for 3 cycles
      $display("reset hold");
      cyc(1'b1, r4(), r1(), 1'b0, '0, "reset_out");
      cyc(1'b1, r4(), r1(), 1'b1, '0, "reset_out");
      for (int i = 0; i < 3; i++) cyc(1'b0, r4(), r1(), 1'b0, o_fetch(1'b0), "fetch_stall");
      cyc(1'b0, r4(), r1(), 1'b1, o_fetch(1'b1), "fetch");
      cyc(1'b0, 4'd4, r1(), r1(), o_decode(1'b0), "decode");
      cyc(1'b0, r4(), r1(), r1(), o_alu(2'b00, 2'b10), "exec_i");
      cyc(1'b0, r4(), r1(), r1(), o_wb(1'b0, 1'b0), "wb_i");

      // Directed cases
      run_instr(4'd0, 1'b0, 0, 0);   // R-type
      run_instr(4'd1, 1'b0, 0, 2);   // LW, 2 wait states
      run_instr(4'd3, 1'b1, 0, 0);   // BEQ taken
      run_instr(4'd3, 1'b0, 0, 0);   // BEQ not taken
      run_instr(4'd6, 1'b0, 0, 0);   // illegal
      run_instr(4'd2, 1'b0, 1, 3);   // SW with waits

      // Randomized instruction stream (HALT excluded)
      for (int n = 0; n < 60; n++) begin
         if (r1()) op = 4'($urandom_range(0, 5));
         else      op = 4'($urandom_range(0, 14));
         run_instr(op, r1(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset mid-SW: mem_write must drop in the reset cycle, then FETCH
      $display("reset during store");
      do_fetch(0);
      cyc(1'b0, 4'd2, r1(), r1(), o_decode(1'b0), "decode");
      cyc(1'b0, r4(), r1(), r1(), o_alu(2'b00, 2'b10), "mem_addr_sw");
      cyc(1'b0, r4(), r1(), 1'b0, o_mem(1'b1), "mem_wait");
      cyc(1'b1, r4(), r1(), 1'b0, '0, "reset_mid_sw");
      run_instr(4'd5, 1'b0, 0, 0);

      // HALT, then reset releases it
      run_instr(HALT, 1'b0, 1, 0);
      $display("reset from halt");
      cyc(1'b1, r4(), r1(), r1(), '0, "reset_halt");
      run_instr(4'd0, 1'b0, 0, 0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
